// File: rtl/sliding_window_sum_pkg.sv
// Shared types and helpers for the per-channel sliding-window popcount engine.
// The RAM word struct is sized for the widest window; narrower builds keep the upper bits zero.
package sliding_window_pkg;

    localparam int MAX_WIN_LEN = 64;
    localparam int MAX_SUM_W   = 7;
    localparam int MAX_WORD_W  = MAX_SUM_W + MAX_WIN_LEN;

    typedef enum logic [4:0] {
        INIT = 5'b00001,
        IDLE = 5'b00010,
        RD   = 5'b00100,
        UPD  = 5'b01000,
        WR   = 5'b10000
    } state_t;

    function automatic int calcSumW(input int winLen);
        return $clog2(winLen + 1);
    endfunction

    typedef struct packed {
        logic [MAX_SUM_W-1:0]   count;
        logic [MAX_WIN_LEN-1:0] hist;
    } ramWord_t;

endpackage

// File: rtl/sliding_window_sum_if.sv
// Request/response bundle of the sliding-window engine: a start strobe with its
// operands, and the ready/done handshake with the registered result.
interface sliding_window_sum_if
    import sliding_window_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SUM_W  = calcSumW(40)
);
    logic              start;
    logic              bits;
    logic              clr;
    logic [ADDR_W-1:0] addr;
    logic [SUM_W-1:0]  thresh;
    logic              ready;
    logic              done;
    logic [SUM_W-1:0]  sum;
    logic              above;
    logic              err;

    modport master (
        output start, bits, clr, addr, thresh,
        input  ready, done, sum, above, err
    );

    modport slave (
        input  start, bits, clr, addr, thresh,
        output ready, done, sum, above, err
    );

endinterface

// File: rtl/sw_hist_ram.sv
// Simple dual-port RAM holding {count, history} per channel; synchronous read with
// one cycle of latency. Kept separate so a vendor macro can be dropped in.
module sw_hist_ram #(
    parameter int WIDTH  = 46,
    parameter int DEPTH  = 600,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sliding_window_sum.sv
// Per-channel sliding-window popcount: each request shifts one bit into a channel's
// history and updates its running one-count incrementally (add new bit, drop oldest).
module sliding_window_sum
    import sliding_window_pkg::*;
#(
    parameter int WIN_LEN = 40,
    parameter int DEPTH   = 600,
    parameter int ADDR_W  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    sliding_window_sum_if.slave  bus
);
    localparam int SUM_W  = calcSumW(WIN_LEN);
    localparam int WORD_W = SUM_W + WIN_LEN;
    localparam logic [MAX_WIN_LEN-1:0] HIST_MASK =
        (MAX_WIN_LEN'(1) << WIN_LEN) - MAX_WIN_LEN'(1);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_clrCnt, r_addr, w_waddr;
    logic              r_bit, r_clr, r_inRange;
    logic [SUM_W-1:0]  r_thresh, r_sum;
    logic              r_above, r_err;
    ramWord_t          r_wrWord, w_rdWord, w_newWord;
    logic [MAX_SUM_W:0] w_cntExt;
    logic [WORD_W-1:0] w_rdata, w_wdata, w_ramWdata;
    logic              w_ready, w_accept, w_lastClr, w_we, w_re;

    assign w_ready   = (r_state == IDLE) || (r_state == WR);
    assign w_accept  = bus.start && w_ready;
    assign w_lastClr = (r_clrCnt == ADDR_W'(DEPTH - 1));

    // Incremental count update; the extra bit catches an impossible underflow and clamps it.
    always_comb begin
        w_rdWord.count  = MAX_SUM_W'(w_rdata >> WIN_LEN);
        w_rdWord.hist   = MAX_WIN_LEN'(w_rdata[WIN_LEN-1:0]);
        w_cntExt        = {1'b0, w_rdWord.count} + (MAX_SUM_W+1)'(r_bit)
                          - (MAX_SUM_W+1)'(w_rdWord.hist[WIN_LEN-1]);
        w_newWord.hist  = ((w_rdWord.hist << 1) | MAX_WIN_LEN'(r_bit)) & HIST_MASK;
        w_newWord.count = w_cntExt[MAX_SUM_W] ? '0 : w_cntExt[MAX_SUM_W-1:0];
        if (r_clr) w_newWord = '0;
    end

    assign w_wdata = WORD_W'((MAX_WORD_W'(r_wrWord.count) << WIN_LEN)
                             | MAX_WORD_W'(r_wrWord.hist));

    // Next state plus RAM port control; writes are suppressed while reset is high.
    always_comb begin
        w_next     = r_state;
        w_we       = 1'b0;
        w_re       = 1'b0;
        w_waddr    = r_clrCnt;
        w_ramWdata = '0;
        case (r_state)
            INIT: begin
                w_we = !reset;
                if (w_lastClr) w_next = IDLE;
            end
            IDLE: if (bus.start) w_next = RD;
            RD: begin
                w_re   = r_inRange;
                w_next = UPD;
            end
            UPD: w_next = WR;
            WR: begin
                w_we       = r_inRange && !reset;
                w_waddr    = r_addr;
                w_ramWdata = w_wdata;
                w_next     = bus.start ? RD : IDLE;
            end
            default: w_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= INIT;
            r_clrCnt <= '0;
            r_sum    <= '0;
            r_above  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == INIT && !w_lastClr) r_clrCnt <= r_clrCnt + ADDR_W'(1);
            if (w_accept) begin
                r_bit     <= bus.bits;
                r_clr     <= bus.clr;
                r_addr    <= bus.addr;
                r_thresh  <= bus.thresh;
                r_inRange <= (32'(bus.addr) < 32'(DEPTH));
            end
            if (r_state == UPD) begin
                r_wrWord <= w_newWord;
                if (r_inRange) begin
                    r_sum   <= SUM_W'(w_newWord.count);
                    r_above <= (w_newWord.count >= MAX_SUM_W'(r_thresh));
                    r_err   <= 1'b0;
                end else begin
                    r_sum   <= '0;
                    r_above <= (r_thresh == '0);
                    r_err   <= 1'b1;
                end
            end
        end
    end

    sw_hist_ram #(
        .WIDTH  (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_ramWdata),
        .i_re    (w_re),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    assign bus.ready = w_ready;
    assign bus.done  = (r_state == WR);
    assign bus.sum   = r_sum;
    assign bus.above = r_above;
    assign bus.err   = r_err;

endmodule

// File: doc/sliding_window_sum.md
# sliding_window_sum

Parametrised per-channel sliding-window popcount engine, the next-generation window block for the bit-stream detector path. Each of DEPTH channels keeps a WIN_LEN-bit history and a running one-count in internal RAM. Every request shifts one bit into the addressed channel and returns the updated count and a threshold flag. The count is updated incrementally (add incoming bit, subtract outgoing bit), so no wide adder tree is needed. The block also supports a per-channel clear and rejects out-of-range addresses.

## Interface
- WIN_LEN, 40: window length in bits, 2..64.
- DEPTH, 600: number of channels (RAM words).
- ADDR_W, 10: address width; must satisfy 2^ADDR_W >= DEPTH.
- SUM_W (localparam): $clog2(WIN_LEN+1); 6 at defaults.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe; accepted only when ready=1.
- bits  in  1  sample shifted into the window; sampled with start.
- clr  in  1  with start: zero the channel instead of shifting.
- addr  in  ADDR_W  channel index; sampled with start.
- thresh  in  SUM_W  compare level; sampled with start.
- ready  out  1  block can accept start this cycle.
- done  out  1  one-cycle pulse: result valid.
- sum  out  SUM_W  updated one-count of the channel; held until the next done.
- above  out  1  sum >= thresh; held with sum.
- err  out  1  addr >= DEPTH on the last request; held with sum.

## Operation
- RAM word is {count[SUM_W-1:0], hist[WIN_LEN-1:0]}, with hist[0] the newest bit.
- States: INIT, IDLE, RD, UPD, WR. Encoding is one-hot.
- INIT: writes zero to addresses 0..DEPTH-1, one per cycle, then goes to IDLE. ready=0 throughout.
  - All DEPTH words are cleared, including the last.
- IDLE: on start, register bits/clr/addr/thresh, then go to RD.
- RD: issue a RAM read of the registered addr, then go to UPD.
- UPD (RAM data valid):
  - new_hist = {hist[WIN_LEN-2:0], bit}.
  - new_cnt = count + bit - hist[WIN_LEN-1].
  - Compute in SUM_W+1 bits. The result never goes negative and never exceeds WIN_LEN.
  - If clr=1: new_hist=0 and new_cnt=0.
  - Register new_cnt into sum and the compare result into above, then go to WR.
- WR: write {new_cnt, new_hist} to addr and pulse done.
  - A start in WR is accepted and the FSM goes to RD; otherwise it goes to IDLE.
- Out-of-range addr (addr >= DEPTH):
  - RD and WR issue no RAM access; the RAM is unchanged.
  - sum=0, above=(thresh==0), err=1; done still pulses.
  - err=0 on every in-range request.
- ready = (state==IDLE) || (state==WR). A start while ready=0 is ignored, not queued.

## Timing
- Reset values: ready=0, done=0, sum=0, above=0, err=0; state=INIT; clear counter=0.
- reset asserted in any state, including mid-request, aborts the request with no write and restarts INIT.
  - The full clear takes DEPTH cycles after reset deasserts.
  - ready first rises in the cycle after the last clear write.
- Latency: start sampled at edge E0 -> RD after E0 -> UPD after E1 -> WR after E2.
  - done, sum, above and err are valid in the cycle after E2.
  - The RAM write commits at E3.
- Throughput: one request per 3 cycles when start is held high.
- Back-to-back requests to the same address: the write commits at E3 and the next read issues at E4. No bypass is needed and the read returns the updated word.
- RAM: simple dual-port, synchronous read, 1-cycle read latency, write-first not required.

## Structure
- Package sliding_window_pkg holds:
  - the state enum;
  - a function computing SUM_W from WIN_LEN;
  - a packed struct type for the RAM word.
- Sub-module sw_hist_ram: DEPTH x (SUM_W+WIN_LEN) simple dual-port RAM with parametrised width and depth. This is the only vendor-replaceable part.
- FSM, INIT clear counter, update datapath and output registers live in the top level.

## Test plan
- Reset for 2 cycles, release -> ready=0 for exactly 600 cycles, then 1. A request to addr 599 with bits=0 -> done, sum=0, err=0.
- 40 requests to addr 5 with bits=1 -> sums 1..40. A 41st with bits=0 -> sum=39. Then 40 with bits=0 -> sum reaches 0.
- start held high, alternating addr 5 (bits=1) and addr 6 (bits=0) -> done every 3 cycles. sum for addr 5 climbs 1,2,3…; addr 6 stays 0.
- thresh=20 with ones into addr 7 -> above=0 through sum=19, above=1 at sum=20. clr=1 on addr 7 -> sum=0, above=0; next bits=1 -> sum=1.
- addr=600 -> done with err=1, sum=0. Then read addr 0 (fresh) -> sum unchanged from before (no stray write).
- Assert reset during UPD after loading addr 3 with ones -> no done, INIT re-runs 600 cycles, addr 3 then returns sum=1 after one bits=1. Repeat with WIN_LEN=8, DEPTH=16 -> saturates at sum=8.
